// File: rtl/exception_ctrl_if.sv
// Bundle between the multi-cycle core (control FSM, PC and EPC registers) and
// the exception sequencer.
interface exception_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  // Core -> sequencer
  logic              instr_done;
  logic              irq;
  logic              illegal_op;
  logic              eret;
  logic [31:0]       pc_cur;
  logic [31:0]       pc_next;
  logic [31:0]       epc_rdata;

  // Sequencer -> core
  logic              epc_write;
  logic [31:0]       epc_wdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              kernel_mode;
  logic [1:0]        cause;
  logic              irq_ack;
  logic              double_fault;
  logic [CNT_W-1:0]  exc_count;

  // Core side
  modport master (
    output instr_done, irq, illegal_op, eret, pc_cur, pc_next, epc_rdata,
    input  epc_write, epc_wdata, redirect, redirect_pc, kernel_mode, cause,
           irq_ack, double_fault, exc_count
  );

  // Sequencer side
  modport slave (
    input  instr_done, irq, illegal_op, eret, pc_cur, pc_next, epc_rdata,
    output epc_write, epc_wdata, redirect, redirect_pc, kernel_mode, cause,
           irq_ack, double_fault, exc_count
  );

endinterface

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: samples sources at instruction boundaries,
// saves the return address to EPC, redirects the PC to the handler and back.
module exception_ctrl #(
  parameter logic [31:0] INT_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  exception_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_KERNEL = 2'd2,
    ST_LEAVE  = 2'd3
  } state_e;

  localparam logic [1:0]  CAUSE_NONE = 2'd0;
  localparam logic [1:0]  CAUSE_IRQ  = 2'd1;
  localparam logic [1:0]  CAUSE_ILL  = 2'd2;
  localparam logic [1:0]  CAUSE_DBL  = 2'd3;
  localparam logic [31:0] KBIT_CLEAR = 32'h7FFF_FFFF;

  state_e           state_q;
  logic             epc_write_q;
  logic [31:0]      epc_wdata_q;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic             kernel_mode_q;
  logic [1:0]       cause_q;
  logic             irq_ack_q;
  logic             double_fault_q;
  logic [CNT_W-1:0] exc_count_q;

  logic [31:0]      epc_ill_d;
  logic [CNT_W-1:0] exc_count_d;

  // Return address for an illegal instruction, and saturating entry count
  always_comb begin
    epc_ill_d   = bus.pc_cur + 32'd4;
    exc_count_d = exc_count_q;
    if (exc_count_q != {CNT_W{1'b1}}) begin
      exc_count_d = exc_count_q + CNT_W'(1);
    end
  end

  // Sequencer FSM; every output is a register updated at the decision edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_USER;
      epc_write_q    <= 1'b0;
      epc_wdata_q    <= 32'd0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 32'd0;
      kernel_mode_q  <= 1'b0;
      cause_q        <= CAUSE_NONE;
      irq_ack_q      <= 1'b0;
      double_fault_q <= 1'b0;
      exc_count_q    <= '0;
    end else begin
      epc_write_q <= 1'b0;
      redirect_q  <= 1'b0;
      irq_ack_q   <= 1'b0;
      case (state_q)
        ST_USER: begin
          if (bus.instr_done) begin
            // eret in user mode is treated as an undefined instruction
            if (bus.illegal_op || bus.eret) begin
              state_q       <= ST_ENTER;
              cause_q       <= CAUSE_ILL;
              epc_wdata_q   <= epc_ill_d;
              epc_write_q   <= 1'b1;
              redirect_q    <= 1'b1;
              redirect_pc_q <= EXC_VECTOR;
            end else if (bus.irq) begin
              state_q       <= ST_ENTER;
              cause_q       <= CAUSE_IRQ;
              epc_wdata_q   <= bus.pc_next;
              epc_write_q   <= 1'b1;
              redirect_q    <= 1'b1;
              redirect_pc_q <= INT_VECTOR;
              irq_ack_q     <= 1'b1;
            end
          end
        end
        ST_ENTER: begin
          state_q       <= ST_KERNEL;
          kernel_mode_q <= 1'b1;
          exc_count_q   <= exc_count_d;
        end
        ST_KERNEL: begin
          if (bus.instr_done) begin
            if (bus.illegal_op) begin
              double_fault_q <= 1'b1;
              cause_q        <= CAUSE_DBL;
            end else if (bus.eret) begin
              // EPC is only written in ENTER, so sampling it here equals
              // sampling it during LEAVE
              state_q       <= ST_LEAVE;
              redirect_q    <= 1'b1;
              redirect_pc_q <= bus.epc_rdata & KBIT_CLEAR;
            end
          end
        end
        ST_LEAVE: begin
          state_q       <= ST_USER;
          kernel_mode_q <= 1'b0;
          cause_q       <= CAUSE_NONE;
        end
        default: state_q <= ST_USER;
      endcase
    end
  end

  assign bus.epc_write    = epc_write_q;
  assign bus.epc_wdata    = epc_wdata_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.kernel_mode  = kernel_mode_q;
  assign bus.cause        = cause_q;
  assign bus.irq_ack      = irq_ack_q;
  assign bus.double_fault = double_fault_q;
  assign bus.exc_count    = exc_count_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl; a second instance with a 4-bit counter
// exercises counter saturation in a short run.
module tb_exception_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  exception_ctrl_if #(.CNT_W(16)) b ();
  exception_ctrl_if #(.CNT_W(4))  s ();

  exception_ctrl #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b));
  exception_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .reset(reset), .bus(s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instr_done with the given decode flags, then idle the strobe
  task automatic instr(input logic ill, input logic er, input logic [31:0] pcc,
                       input logic [31:0] pcn);
    b.illegal_op = ill;
    b.eret       = er;
    b.pc_cur     = pcc;
    b.pc_next    = pcn;
    b.instr_done = 1'b1;
    step();
    b.instr_done = 1'b0;
    b.illegal_op = 1'b0;
    b.eret       = 1'b0;
  endtask

  // Leave the handler via eret with the given EPC contents (two cycles)
  task automatic leave(input logic [31:0] epc);
    b.epc_rdata = epc;
    instr(1'b0, 1'b1, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b.instr_done = 0; b.irq = 0; b.illegal_op = 0; b.eret = 0;
    b.pc_cur = 0; b.pc_next = 0; b.epc_rdata = 0;
    s.instr_done = 0; s.irq = 0; s.illegal_op = 0; s.eret = 0;
    s.pc_cur = 0; s.pc_next = 0; s.epc_rdata = 0;
    step();
    step();
    reset = 1'b0;
    n_vec++; if (b.epc_write !== 1'b0) begin n_err++; $display("FAIL rst_epc_write got=%b exp=0", b.epc_write); end
    n_vec++; if (b.epc_wdata !== 32'h0) begin n_err++; $display("FAIL rst_epc_wdata got=%h exp=0", b.epc_wdata); end
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect got=%b exp=0", b.redirect); end
    n_vec++; if (b.redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_redirect_pc got=%h exp=0", b.redirect_pc); end
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL rst_kernel got=%b exp=0", b.kernel_mode); end
    n_vec++; if (b.cause !== 2'd0) begin n_err++; $display("FAIL rst_cause got=%0d exp=0", b.cause); end
    n_vec++; if (b.irq_ack !== 1'b0) begin n_err++; $display("FAIL rst_irq_ack got=%b exp=0", b.irq_ack); end
    n_vec++; if (b.double_fault !== 1'b0) begin n_err++; $display("FAIL rst_dfault got=%b exp=0", b.double_fault); end
    n_vec++; if (b.exc_count !== 16'h0) begin n_err++; $display("FAIL rst_count got=%h exp=0", b.exc_count); end
  endtask

  task automatic test_illegal();
    instr(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0014);
    n_vec++; if (b.epc_write !== 1'b1) begin n_err++; $display("FAIL ill_epc_write got=%b exp=1", b.epc_write); end
    n_vec++; if (b.epc_wdata !== 32'h14) begin n_err++; $display("FAIL ill_epc_wdata got=%h exp=14", b.epc_wdata); end
    n_vec++; if (b.redirect !== 1'b1) begin n_err++; $display("FAIL ill_redirect got=%b exp=1", b.redirect); end
    n_vec++; if (b.redirect_pc !== 32'h8000_0008) begin n_err++; $display("FAIL ill_vector got=%h exp=80000008", b.redirect_pc); end
    n_vec++; if (b.cause !== 2'd2) begin n_err++; $display("FAIL ill_cause got=%0d exp=2", b.cause); end
    n_vec++; if (b.irq_ack !== 1'b0) begin n_err++; $display("FAIL ill_irq_ack got=%b exp=0", b.irq_ack); end
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL ill_kernel_enter got=%b exp=0", b.kernel_mode); end
    step();
    n_vec++; if (b.kernel_mode !== 1'b1) begin n_err++; $display("FAIL ill_kernel got=%b exp=1", b.kernel_mode); end
    n_vec++; if (b.exc_count !== 16'd1) begin n_err++; $display("FAIL ill_count got=%0d exp=1", b.exc_count); end
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL ill_redirect_drop got=%b exp=0", b.redirect); end
    n_vec++; if (b.epc_write !== 1'b0) begin n_err++; $display("FAIL ill_epc_write_drop got=%b exp=0", b.epc_write); end
    leave(32'h0000_0014);
  endtask

  task automatic test_irq();
    b.irq = 1'b1;
    instr(1'b0, 1'b0, 32'h0000_003C, 32'h0000_0040);
    n_vec++; if (b.epc_wdata !== 32'h40) begin n_err++; $display("FAIL irq_epc_wdata got=%h exp=40", b.epc_wdata); end
    n_vec++; if (b.redirect_pc !== 32'h8000_0004) begin n_err++; $display("FAIL irq_vector got=%h exp=80000004", b.redirect_pc); end
    n_vec++; if (b.irq_ack !== 1'b1) begin n_err++; $display("FAIL irq_ack got=%b exp=1", b.irq_ack); end
    n_vec++; if (b.cause !== 2'd1) begin n_err++; $display("FAIL irq_cause got=%0d exp=1", b.cause); end
    step();
    n_vec++; if (b.irq_ack !== 1'b0) begin n_err++; $display("FAIL irq_ack_pulse got=%b exp=0", b.irq_ack); end
    n_vec++; if (b.exc_count !== 16'd2) begin n_err++; $display("FAIL irq_count got=%0d exp=2", b.exc_count); end
    // irq still high in kernel mode must not cause a second entry
    for (int i = 0; i < 3; i++) begin
      instr(1'b0, 1'b0, 32'h8000_0004, 32'h8000_0008);
      n_vec++; if (b.redirect !== 1'b0 || b.epc_write !== 1'b0) begin n_err++; $display("FAIL irq_masked[%0d] got redirect=%b epc_write=%b exp=0,0", i, b.redirect, b.epc_write); end
    end
    n_vec++; if (b.exc_count !== 16'd2) begin n_err++; $display("FAIL irq_masked_count got=%0d exp=2", b.exc_count); end
    b.irq = 1'b0;
  endtask

  task automatic test_eret();
    b.epc_rdata = 32'h8000_0040;
    instr(1'b0, 1'b1, 32'h8000_0010, 32'h8000_0014);
    n_vec++; if (b.redirect !== 1'b1) begin n_err++; $display("FAIL eret_redirect got=%b exp=1", b.redirect); end
    n_vec++; if (b.redirect_pc !== 32'h0000_0040) begin n_err++; $display("FAIL eret_target got=%h exp=40", b.redirect_pc); end
    n_vec++; if (b.epc_write !== 1'b0) begin n_err++; $display("FAIL eret_epc_write got=%b exp=0", b.epc_write); end
    step();
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL eret_kernel got=%b exp=0", b.kernel_mode); end
    n_vec++; if (b.cause !== 2'd0) begin n_err++; $display("FAIL eret_cause got=%0d exp=0", b.cause); end
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL eret_redirect_drop got=%b exp=0", b.redirect); end
  endtask

  task automatic test_priority();
    b.irq = 1'b1;
    instr(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0104);
    n_vec++; if (b.cause !== 2'd2) begin n_err++; $display("FAIL prio_cause got=%0d exp=2", b.cause); end
    n_vec++; if (b.irq_ack !== 1'b0) begin n_err++; $display("FAIL prio_irq_ack got=%b exp=0", b.irq_ack); end
    n_vec++; if (b.redirect_pc !== 32'h8000_0008) begin n_err++; $display("FAIL prio_vector got=%h exp=80000008", b.redirect_pc); end
    n_vec++; if (b.epc_wdata !== 32'h104) begin n_err++; $display("FAIL prio_epc got=%h exp=104", b.epc_wdata); end
    step();
    n_vec++; if (b.exc_count !== 16'd3) begin n_err++; $display("FAIL prio_count got=%0d exp=3", b.exc_count); end
    leave(32'h0000_0104);
    // pending level irq is taken at the next boundary in user mode
    instr(1'b0, 1'b0, 32'h0000_0104, 32'h0000_0200);
    n_vec++; if (b.cause !== 2'd1) begin n_err++; $display("FAIL prio_irq_cause got=%0d exp=1", b.cause); end
    n_vec++; if (b.irq_ack !== 1'b1) begin n_err++; $display("FAIL prio_irq_ack2 got=%b exp=1", b.irq_ack); end
    n_vec++; if (b.epc_wdata !== 32'h200) begin n_err++; $display("FAIL prio_irq_epc got=%h exp=200", b.epc_wdata); end
    b.irq = 1'b0;
    step();
    n_vec++; if (b.exc_count !== 16'd4) begin n_err++; $display("FAIL prio_count2 got=%0d exp=4", b.exc_count); end
    leave(32'h0000_0200);
  endtask

  task automatic test_user_eret();
    instr(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0304);
    n_vec++; if (b.redirect !== 1'b1) begin n_err++; $display("FAIL ueret_redirect got=%b exp=1", b.redirect); end
    n_vec++; if (b.cause !== 2'd2) begin n_err++; $display("FAIL ueret_cause got=%0d exp=2", b.cause); end
    n_vec++; if (b.redirect_pc !== 32'h8000_0008) begin n_err++; $display("FAIL ueret_vector got=%h exp=80000008", b.redirect_pc); end
    n_vec++; if (b.epc_wdata !== 32'h304) begin n_err++; $display("FAIL ueret_epc got=%h exp=304", b.epc_wdata); end
    step();
    n_vec++; if (b.exc_count !== 16'd5) begin n_err++; $display("FAIL ueret_count got=%0d exp=5", b.exc_count); end
  endtask

  task automatic test_double_fault();
    instr(1'b1, 1'b0, 32'h8000_0020, 32'h8000_0024);
    n_vec++; if (b.double_fault !== 1'b1) begin n_err++; $display("FAIL df_flag got=%b exp=1", b.double_fault); end
    n_vec++; if (b.cause !== 2'd3) begin n_err++; $display("FAIL df_cause got=%0d exp=3", b.cause); end
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL df_redirect got=%b exp=0", b.redirect); end
    n_vec++; if (b.epc_write !== 1'b0) begin n_err++; $display("FAIL df_epc_write got=%b exp=0", b.epc_write); end
    n_vec++; if (b.kernel_mode !== 1'b1) begin n_err++; $display("FAIL df_kernel got=%b exp=1", b.kernel_mode); end
    n_vec++; if (b.epc_wdata !== 32'h304) begin n_err++; $display("FAIL df_epc_hold got=%h exp=304", b.epc_wdata); end
    step();
    n_vec++; if (b.exc_count !== 16'd5) begin n_err++; $display("FAIL df_count got=%0d exp=5", b.exc_count); end
    leave(32'h0000_0304);
    n_vec++; if (b.double_fault !== 1'b1) begin n_err++; $display("FAIL df_sticky got=%b exp=1", b.double_fault); end
    n_vec++; if (b.cause !== 2'd0) begin n_err++; $display("FAIL df_cause_clr got=%0d exp=0", b.cause); end
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL df_kernel_clr got=%b exp=0", b.kernel_mode); end
  endtask

  task automatic test_wrap();
    instr(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000);
    n_vec++; if (b.epc_wdata !== 32'h0) begin n_err++; $display("FAIL wrap_epc got=%h exp=0", b.epc_wdata); end
    step();
    n_vec++; if (b.exc_count !== 16'd6) begin n_err++; $display("FAIL wrap_count got=%0d exp=6", b.exc_count); end
    leave(32'h0000_0000);
  endtask

  task automatic test_done_ignored();
    instr(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0024);
    // strobe during ENTER must not start a return
    instr(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0024);
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL ign_enter_redirect got=%b exp=0", b.redirect); end
    n_vec++; if (b.kernel_mode !== 1'b1) begin n_err++; $display("FAIL ign_enter_kernel got=%b exp=1", b.kernel_mode); end
    n_vec++; if (b.exc_count !== 16'd7) begin n_err++; $display("FAIL ign_count got=%0d exp=7", b.exc_count); end
    b.epc_rdata = 32'h0000_0024;
    instr(1'b0, 1'b1, 32'h8000_0008, 32'h8000_000C);
    // strobe during LEAVE must not start a new entry
    instr(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0504);
    n_vec++; if (b.redirect !== 1'b0 || b.epc_write !== 1'b0) begin n_err++; $display("FAIL ign_leave got redirect=%b epc_write=%b exp=0,0", b.redirect, b.epc_write); end
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL ign_leave_kernel got=%b exp=0", b.kernel_mode); end
    n_vec++; if (b.cause !== 2'd0) begin n_err++; $display("FAIL ign_leave_cause got=%0d exp=0", b.cause); end
    step();
    n_vec++; if (b.redirect !== 1'b0 || b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL ign_leave_late got redirect=%b kernel=%b exp=0,0", b.redirect, b.kernel_mode); end
  endtask

  task automatic test_reset_in_enter();
    instr(1'b1, 1'b0, 32'h0000_0600, 32'h0000_0604);
    n_vec++; if (b.redirect !== 1'b1) begin n_err++; $display("FAIL rie_pre_redirect got=%b exp=1", b.redirect); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (b.redirect !== 1'b0) begin n_err++; $display("FAIL rie_redirect got=%b exp=0", b.redirect); end
    n_vec++; if (b.epc_write !== 1'b0) begin n_err++; $display("FAIL rie_epc_write got=%b exp=0", b.epc_write); end
    n_vec++; if (b.kernel_mode !== 1'b0) begin n_err++; $display("FAIL rie_kernel got=%b exp=0", b.kernel_mode); end
    n_vec++; if (b.exc_count !== 16'd0) begin n_err++; $display("FAIL rie_count got=%0d exp=0", b.exc_count); end
    n_vec++; if (b.double_fault !== 1'b0) begin n_err++; $display("FAIL rie_dfault got=%b exp=0", b.double_fault); end
    n_vec++; if (b.epc_wdata !== 32'h0) begin n_err++; $display("FAIL rie_epc_wdata got=%h exp=0", b.epc_wdata); end
    step();
    n_vec++; if (b.kernel_mode !== 1'b0 || b.redirect !== 1'b0) begin n_err++; $display("FAIL rie_idle got kernel=%b redirect=%b exp=0,0", b.kernel_mode, b.redirect); end
    // back in USER: a fresh illegal instruction is accepted
    instr(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0014);
    n_vec++; if (b.cause !== 2'd2 || b.epc_wdata !== 32'h14) begin n_err++; $display("FAIL rie_user got cause=%0d epc=%h exp=2,14", b.cause, b.epc_wdata); end
    step();
    n_vec++; if (b.exc_count !== 16'd1) begin n_err++; $display("FAIL rie_count2 got=%0d exp=1", b.exc_count); end
    leave(32'h0000_0014);
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd0;
    for (int i = 0; i < 17; i++) begin
      s.illegal_op = 1'b1; s.pc_cur = 32'h0000_0040; s.instr_done = 1'b1;
      step();
      s.illegal_op = 1'b0; s.instr_done = 1'b0;
      step();
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      n_vec++; if (s.exc_count !== exp_cnt) begin n_err++; $display("FAIL sat_count[%0d] got=%h exp=%h", i, s.exc_count, exp_cnt); end
      s.eret = 1'b1; s.epc_rdata = 32'h0000_0044; s.instr_done = 1'b1;
      step();
      s.eret = 1'b0; s.instr_done = 1'b0;
      step();
    end
    n_vec++; if (s.exc_count !== 4'hF) begin n_err++; $display("FAIL sat_final got=%h exp=f", s.exc_count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_illegal();
    test_irq();
    test_eret();
    test_priority();
    test_user_eret();
    test_double_fault();
    test_wrap();
    test_done_ignored();
    test_reset_in_enter();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
